td4_out_logger: RTL and testbench

- Downstream consumer of the TD4 output port (the 4-bit value of register C).
- Detects changes on that port, buffers each new value in a small FIFO, and serialises it as an ASCII hex digit followed by LF over a UART 8N1 transmit line.
- Lets the bench or board log program output without a logic analyser.
- Sits beside the CPU top, sharing its clock. The CPU advances only on cycles where sample_en is high.

---
 rtl/td4_out_logger.sv | 172 +++++++++++++++++
 tb/tb_td4_out_logger.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_out_logger.sv
// td4_out_logger: watches the TD4 output port (register C), queues each new
// value in a small FIFO and sends it on a UART 8N1 line as one ASCII hex
// digit followed by LF.
module td4_out_logger #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] outp_in,
  input  logic       sample_en,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic [4:0] fifo_count
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [4:0]  DEPTH_C   = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  tx_state_t     state;
  logic [3:0]    last_val;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_byte;
  logic          phase;      // 0: sending the hex digit, 1: sending the LF

  logic          change;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic [3:0]    head;
  logic [7:0]    head_ascii;
  logic          baud_done;

  // FIFO handshake: the change detector offers a nibble (change); it is
  // accepted (push_ok) when the FIFO has room or an entry leaves in the same
  // cycle. The transmitter takes the head (pop) only while IDLE and the FIFO
  // is non-empty; a pop is never refused. A refused offer is lost and flagged.
  always_comb begin
    change     = sample_en && (outp_in != last_val);
    fifo_empty = (fifo_count == 5'd0);
    fifo_full  = (fifo_count == DEPTH_C);
    pop        = (state == IDLE) && !fifo_empty;
    push_ok    = change && (!fifo_full || pop);
    head       = mem[rd_ptr];
    head_ascii = (head < 4'd10) ? (8'h30 + {4'h0, head}) : (8'h37 + {4'h0, head});
    baud_done  = (baud_cnt == BAUD_LAST);
  end

  // Change detection, FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_val   <= 4'h0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 5'd0;
      overflow   <= 1'b0;
    end else begin
      if (change) begin
        last_val <= outp_in;
      end
      if (change && !push_ok) begin
        overflow <= 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= outp_in;
    end
  end

  // Transmitter sequencing: digit frame, then LF frame, per FIFO entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= 16'd0;
      bit_idx    <= 3'd0;
      shift_byte <= 8'h00;
      phase      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= 16'd0;
          if (pop) begin
            shift_byte <= head_ascii;
            phase      <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= 16'd0;
            if (!phase) begin
              shift_byte <= 8'h0A;
              phase      <= 1'b1;
              state      <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered line level and busy flag; both trail the state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx   <= 1'b1;
      busy <= 1'b0;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_byte[bit_idx];
        default: tx <= 1'b1;
      endcase
      busy <= !fifo_empty || (state != IDLE);
    end
  end

endmodule

// File: tb/tb_td4_out_logger.sv
// Directed bench for td4_out_logger: drives CPU-step samples, decodes the UART
// line and compares every received byte against an expected queue.
module tb_td4_out_logger;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int MID        = CLK_DIV / 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] outp_in;
  logic       sample_en;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [4:0] fifo_count;

  int n_cmp;
  int n_fail;

  logic [7:0] exp_q[$];

  td4_out_logger #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .outp_in    (outp_in),
    .sample_en  (sample_en),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 2000000", $time);
    $fatal(1, "global timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // UART receiver / scoreboard
  logic       mon_active;
  int         mon_cnt;
  logic [7:0] mon_shift;
  int         rx_frames;

  initial begin
    mon_active = 1'b0;
    mon_cnt    = 0;
    mon_shift  = 8'h00;
    rx_frames  = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt >= MID && ((mon_cnt - MID) % CLK_DIV) == 0) begin
        int k;
        k = (mon_cnt - MID) / CLK_DIV;
        if (k == 0) begin
          check_val("rx_start_bit", tx, 1'b0);
        end else if (k <= 8) begin
          mon_shift = {tx, mon_shift[7:1]};
        end else begin
          check_val("rx_stop_bit", tx, 1'b1);
          rx_frames++;
          check_val("rx_frame_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            check_val("rx_byte", mon_shift, exp_q.pop_front());
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  // Driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    sample_en = 1'b0;
    outp_in   = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_sample(input logic [3:0] v);
    outp_in   = v;
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic expect_entry(input logic [3:0] v);
    logic [7:0] c;
    c = (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h41 + {4'h0, v} - 8'd10);
    exp_q.push_back(c);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    logic timed_out;
    n = 0;
    timed_out = 1'b1;
    while (n < budget) begin
      cycles(1);
      n++;
      if (!busy && !mon_active) begin
        timed_out = 1'b0;
        break;
      end
    end
    check_val(tag, timed_out, 1'b0);
  endtask

  // Directed sequence
  initial begin
    int f0;
    logic low_seen;
    logic [3:0] ov_exp [7];
    logic [4:0] cnt_exp [7];

    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    sample_en = 1'b0;
    outp_in   = 4'h0;

    // Test 1: reset values, single entry '5'
    apply_reset();
    check_val("rst_tx", tx, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_overflow", overflow, 1'b0);
    check_val("rst_fifo_count", fifo_count, 5'd0);
    cycles(2);
    f0 = rx_frames;
    expect_entry(4'h5);
    drive_sample(4'h5);
    check_val("t1_push_count", fifo_count, 5'd1);
    check_val("t1_push_busy", busy, 1'b0);
    check_val("t1_push_tx", tx, 1'b1);
    cycles(1);
    check_val("t1_pop_count", fifo_count, 5'd0);
    check_val("t1_pop_busy", busy, 1'b1);
    check_val("t1_pop_tx", tx, 1'b1);
    cycles(1);
    check_val("t1_start_tx", tx, 1'b0);
    cycles(79);
    check_val("t1_busy_before_end", busy, 1'b1);
    cycles(1);
    check_val("t1_busy_fall", busy, 1'b0);
    check_val("t1_tx_idle", tx, 1'b1);
    check_val("t1_count_end", fifo_count, 5'd0);
    check_val("t1_all_bytes", exp_q.size(), 0);
    check_val("t1_frames", rx_frames - f0, 2);

    // Test 2: repeated values are not pushed
    f0 = rx_frames;
    expect_entry(4'h3);
    expect_entry(4'hC);
    drive_sample(4'h3);
    check_val("t2_count_a", fifo_count, 5'd1);
    drive_sample(4'h3);
    check_val("t2_count_b", fifo_count, 5'd0);
    drive_sample(4'h3);
    check_val("t2_count_c", fifo_count, 5'd0);
    drive_sample(4'hC);
    check_val("t2_count_d", fifo_count, 5'd1);
    wait_idle("t2_idle_timeout", 1000);
    check_val("t2_all_bytes", exp_q.size(), 0);
    check_val("t2_frames", rx_frames - f0, 4);

    // Test 3: no sampling without sample_en
    f0 = rx_frames;
    low_seen = 1'b0;
    outp_in = 4'h7;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      if (tx == 1'b0) low_seen = 1'b1;
    end
    check_val("t3_quiet_tx", low_seen, 1'b0);
    check_val("t3_quiet_count", fifo_count, 5'd0);
    check_val("t3_quiet_busy", busy, 1'b0);
    check_val("t3_quiet_frames", rx_frames - f0, 0);
    expect_entry(4'h7);
    drive_sample(4'h7);
    check_val("t3_push_count", fifo_count, 5'd1);
    wait_idle("t3_idle_timeout", 1000);
    check_val("t3_all_bytes", exp_q.size(), 0);
    check_val("t3_frames", rx_frames - f0, 2);

    // Test 4: overflow with values 1..7 on consecutive steps
    f0 = rx_frames;
    cnt_exp = '{5'd1, 5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd4};
    ov_exp  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1};
    for (int v = 1; v <= 5; v++) expect_entry(4'(v));
    for (int v = 1; v <= 7; v++) begin
      drive_sample(4'(v));
      check_val($sformatf("t4_count_%0d", v), fifo_count, cnt_exp[v-1]);
      check_val($sformatf("t4_overflow_%0d", v), overflow, ov_exp[v-1][0]);
    end
    cycles(50);
    check_val("t4_overflow_held", overflow, 1'b1);
    wait_idle("t4_idle_timeout", 2000);
    check_val("t4_all_bytes", exp_q.size(), 0);
    check_val("t4_frames", rx_frames - f0, 10);
    check_val("t4_overflow_end", overflow, 1'b1);

    // Test 5: push into a full FIFO in the same cycle as a pop
    apply_reset();
    check_val("t5_rst_overflow", overflow, 1'b0);
    f0 = rx_frames;
    for (int v = 1; v <= 6; v++) expect_entry(4'(v));
    for (int v = 1; v <= 5; v++) drive_sample(4'(v));
    check_val("t5_full", fifo_count, 5'd4);
    cycles(77);
    check_val("t5_full_before_pop", fifo_count, 5'd4);
    drive_sample(4'h6);
    check_val("t5_count_kept", fifo_count, 5'd4);
    check_val("t5_no_overflow", overflow, 1'b0);
    check_val("t5_busy", busy, 1'b1);
    wait_idle("t5_idle_timeout", 2000);
    check_val("t5_all_bytes", exp_q.size(), 0);
    check_val("t5_frames", rx_frames - f0, 12);
    check_val("t5_overflow_end", overflow, 1'b0);

    // Test 6: asynchronous reset during the second entry's data bits
    apply_reset();
    expect_entry(4'h1);
    for (int v = 1; v <= 5; v++) drive_sample(4'(v));
    cycles(84);
    check_val("t6_first_done", exp_q.size(), 0);
    check_val("t6_pre_tx_bit0", tx, 1'b0);
    check_val("t6_pre_count", fifo_count, 5'd3);
    check_val("t6_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #2;
    check_val("t6_rst_tx", tx, 1'b1);
    check_val("t6_rst_count", fifo_count, 5'd0);
    check_val("t6_rst_busy", busy, 1'b0);
    check_val("t6_rst_overflow", overflow, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycles(2);
    f0 = rx_frames;
    drive_sample(4'h0);
    check_val("t6_zero_count", fifo_count, 5'd0);
    cycles(1);
    check_val("t6_zero_busy", busy, 1'b0);
    expect_entry(4'h9);
    drive_sample(4'h9);
    check_val("t6_nine_count", fifo_count, 5'd1);
    wait_idle("t6_idle_timeout", 1000);
    check_val("t6_all_bytes", exp_q.size(), 0);
    check_val("t6_frames", rx_frames - f0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
